// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: compare codes, branch conditions and resolver states
package branch_resolve_pkg;
  localparam logic [1:0] COMP_EQ  = 2'b00;
  localparam logic [1:0] COMP_LE  = 2'b01;
  localparam logic [1:0] COMP_GE  = 2'b10;
  localparam logic [1:0] COMP_INV = 2'b11;
  typedef enum logic [2:0] {
    BR_NEVER, BR_ALWAYS, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LE, BR_GT
  } br_cond_t;
  typedef enum logic {BRS_IDLE, BRS_HOLD} brs_state_t;
endpackage

// File: rtl/branch_resolve_cond_eval.sv
// branch_resolve_cond_eval: combinational condition-code evaluation against compare flags
module branch_resolve_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [1:0] flags,
  input  logic       flags_valid,
  input  logic [2:0] cond,
  output logic       taken
);
  logic eq, lt, gt;
  always_comb begin
    eq = flags == COMP_EQ;
    lt = flags == COMP_LE;
    gt = flags == COMP_GE;
    taken = cond == BR_ALWAYS ? 1'b1 :
            !flags_valid      ? 1'b0 :
            cond == BR_EQ     ? eq :
            cond == BR_NE     ? !eq :
            cond == BR_LT     ? lt :
            cond == BR_GE     ? eq || gt :
            cond == BR_LE     ? eq || lt :
            cond == BR_GT     ? gt : 1'b0;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: flags register, conditional-jump evaluation and held PC redirect with flush
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int CPU_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmp_we,
  input  logic [1:0]           cmp_in,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [2:0]           br_cond,
  input  logic [CPU_WIDTH-1:0] br_target,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 flush,
  output logic [1:0]           flags,
  output logic                 flags_valid,
  output logic [CNT_WIDTH-1:0] taken_cnt
);
  brs_state_t state;
  logic [1:0] eff_flags;
  logic       eff_valid, taken;
  // Same-cycle compare result bypasses the flags register
  always_comb begin
    eff_flags = cmp_we ? cmp_in : flags;
    eff_valid = cmp_we ? cmp_in != COMP_INV : flags_valid;
    br_ready  = state == BRS_IDLE;
  end
  branch_resolve_cond_eval u_cond_eval (
    .flags       (eff_flags),
    .flags_valid (eff_valid),
    .cond        (br_cond),
    .taken       (taken)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= BRS_IDLE;
      flags          <= COMP_INV;
      flags_valid    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      taken_cnt      <= '0;
    end else begin
      flush <= 1'b0;
      if (cmp_we) begin
        flags       <= cmp_in;
        flags_valid <= cmp_in != COMP_INV;
      end
      if (state == BRS_IDLE) begin
        if (br_valid && taken) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= br_target;
          flush          <= 1'b1;
          taken_cnt      <= taken_cnt + 1'b1;
          state          <= BRS_HOLD;
        end
      end else if (redirect_ready) begin
        redirect_valid <= 1'b0;
        state          <= BRS_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed plus random stimulus against a relational model with a redirect scoreboard
module tb_branch_resolve;
  import branch_resolve_pkg::*;
  logic        clk = 0, rst_n = 0, cmp_we = 0, br_valid = 0, redirect_ready = 0;
  logic [1:0]  cmp_in = 0;
  logic [2:0]  br_cond = 0;
  logic [15:0] br_target = 0;
  logic        br_ready, redirect_valid, flush, flags_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  flags;
  logic [3:0]  taken_cnt;
  int pass_cnt = 0, total = 0;
  typedef enum {R_NONE, R_EQ, R_LT, R_GT} rel_t;
  rel_t m_rel = R_NONE;
  bit m_hold = 0, m_flush = 0;
  int m_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_pc = 0;

  branch_resolve #(.CPU_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmp_we(cmp_we), .cmp_in(cmp_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .flags(flags), .flags_valid(flags_valid), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic rel_t to_rel(logic [1:0] c);
    return c == 2'b00 ? R_EQ : c == 2'b01 ? R_LT : c == 2'b10 ? R_GT : R_NONE;
  endfunction

  function automatic logic [1:0] rel_code(rel_t r);
    return r == R_EQ ? 2'b00 : r == R_LT ? 2'b01 : r == R_GT ? 2'b10 : 2'b11;
  endfunction

  function automatic bit m_taken(logic [2:0] c, rel_t r);
    if (c == 3'd1) return 1;
    if (r == R_NONE) return 0;
    case (c)
      3'd2: return r == R_EQ;
      3'd3: return r != R_EQ;
      3'd4: return r == R_LT;
      3'd5: return r != R_LT;
      3'd6: return r != R_GT;
      3'd7: return r == R_GT;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model advances on each rising edge from the inputs held across it
  always @(posedge clk) begin
    rel_t e;
    if (!rst_n) begin
      m_rel = R_NONE; m_hold = 0; m_flush = 0; m_cnt = 0; exp_q.delete();
    end else begin
      e = cmp_we ? to_rel(cmp_in) : m_rel;
      m_flush = 0;
      if (m_hold) begin
        if (redirect_ready) m_hold = 0;
      end else if (br_valid && m_taken(br_cond, e)) begin
        m_hold = 1; m_flush = 1; m_cnt = (m_cnt + 1) % 16;
        exp_q.push_back(br_target);
      end
      if (cmp_we) m_rel = to_rel(cmp_in);
    end
  end

  always @(negedge clk) begin
    chk("flags", flags, rel_code(m_rel));
    chk("flags_valid", flags_valid, m_rel != R_NONE);
    chk("taken_cnt", taken_cnt, m_cnt);
    chk("br_ready", br_ready, !m_hold);
    chk("redirect_valid", redirect_valid, m_hold);
    chk("flush", flush, m_flush);
    if (redirect_valid && flush) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL redirect_unexpected: got pc %0h expected none", redirect_pc);
      end else begin
        cur_pc = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, cur_pc);
      end
    end else if (redirect_valid) chk("redirect_pc_stable", redirect_pc, cur_pc);
  end

  task automatic cyc(logic r, logic we, logic [1:0] ci, logic bv, logic [2:0] c,
                     logic [15:0] t, logic rr);
    rst_n = r; cmp_we = we; cmp_in = ci; br_valid = bv; br_cond = c;
    br_target = t; redirect_ready = rr;
    @(negedge clk); #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", redirect_pc, 0);
    cyc(1, 0, 0, 1, BR_EQ, 16'h0010, 0);
    cyc(1, 0, 0, 1, BR_ALWAYS, 16'h0040, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, COMP_LE, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, BR_LT, 16'h1234, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, COMP_EQ, 0, 0, 0, 0);
    cyc(1, 1, COMP_GE, 1, BR_GT, 16'h2222, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, COMP_EQ, 0, 0, 0, 0);
    cyc(1, 1, COMP_GE, 1, BR_EQ, 16'h3333, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, BR_ALWAYS, 16'h4444, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, BR_ALWAYS, 16'h5555, 0);
    cyc(1, 1, COMP_LE, 1, BR_ALWAYS, 16'h5555, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, BR_ALWAYS, 16'h6666, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_hold_pc", redirect_pc, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 1, BR_ALWAYS, 16'(16'h7000 + i), 0);
      cyc(1, 0, 0, 0, 0, 0, 1);
    end
    chk("wrap", taken_cnt, 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(99) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
          3'($urandom), 16'($urandom), $urandom_range(2) == 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
